// File: rtl/so_pkg.sv
// -----------------------------------------------------------------------------
// so_pkg
// Shared definitions for the round-robin process scheduler.
//   - state_t   : scheduler FSM states
//   - PID_SO    : process id owned by the SO/BIOS (no user process)
//   - NUM_PROC  : number of schedulable user processes (ids 1..NUM_PROC)
//   - PID_W     : width of a process id
//   - pid_succ  : next id in the ring 1 -> 2 -> 3 -> 1
// -----------------------------------------------------------------------------
package so_pkg;

    localparam int NUM_PROC = 3;
    localparam int PID_W    = 2;

    localparam logic [PID_W-1:0] PID_SO = '0;

    typedef enum logic [2:0] {
        S_SO      = 3'd0,
        S_SEL     = 3'd1,
        S_RESTORE = 3'd2,
        S_RUN     = 3'd3,
        S_SAVE    = 3'd4,
        S_EXIT    = 3'd5
    } state_t;

    // Id 0 (SO) has no successor of its own; treating it like 3 starts the
    // ring at process 1.
    function automatic logic [PID_W-1:0] pid_succ(input logic [PID_W-1:0] pid);
        logic [PID_W-1:0] nxt;
        case (pid)
            2'd1:    nxt = 2'd2;
            2'd2:    nxt = 2'd3;
            default: nxt = 2'd1;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/seletor_rr.sv
// -----------------------------------------------------------------------------
// seletor_rr
// Combinational round-robin picker. Returns the first ready process id found
// after last_pid in the ring 1 -> 2 -> 3 -> 1. last_pid itself is checked
// last, so a lone ready process is re-selected.
//
// Ports
//   mask      in  [NUM_PROC] bit i-1 set = process i ready
//   last_pid  in  [PID_W]    process selected most recently
//   next_pid  out [PID_W]    chosen process (PID_SO when none ready)
//   valid     out            a ready process was found
// -----------------------------------------------------------------------------
module seletor_rr
    import so_pkg::*;
(
    input  logic [NUM_PROC-1:0] mask,
    input  logic [PID_W-1:0]    last_pid,
    output logic [PID_W-1:0]    next_pid,
    output logic                valid
);

    logic [PID_W-1:0] cand_1;
    logic [PID_W-1:0] cand_2;
    logic [PID_W-1:0] cand_3;

    assign cand_1 = pid_succ(last_pid);
    assign cand_2 = pid_succ(cand_1);
    assign cand_3 = pid_succ(cand_2);

    always_comb begin
        next_pid = PID_SO;
        valid    = 1'b0;
        if (mask[cand_1 - 2'd1]) begin
            next_pid = cand_1;
            valid    = 1'b1;
        end else if (mask[cand_2 - 2'd1]) begin
            next_pid = cand_2;
            valid    = 1'b1;
        end else if (mask[cand_3 - 2'd1]) begin
            next_pid = cand_3;
            valid    = 1'b1;
        end
    end

endmodule

// File: rtl/escalonador_rr.sv
// -----------------------------------------------------------------------------
// escalonador_rr
// Round-robin process scheduler. Hands the CPU/memory partitions to one of
// three user processes, sequencing context restore, run, context save and
// return to the SO/BIOS. All outputs are Moore-decoded from registered state.
//
// Build option
//   ESCALONADOR_QUANTUM_EN  defined   : internal 8-bit slice counter, expiry
//                                       after QUANTUM RUN cycles, the
//                                       quantum_over input is ignored.
//                           undefined : expiry = quantum_over, QUANTUM unused.
//
// Parameters
//   QUANTUM       time slice in clk cycles (1..255)
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-low reset
//   proc_add      in   one-cycle pulse: mark proc_add_id ready
//   proc_add_id   in   [2] id to mark ready (0 ignored)
//   HALT          in   running process finished (sampled in S_RUN)
//   quantum_over  in   external time-slice expiry
//   preemp_mode   in   1 = preemptive round-robin, 0 = run until HALT
//   id_proc       out  [2] process owning CPU/memory (0 = SO)
//   Sel_BIOS      out  SO/BIOS owns the CPU
//   Set_ctx       out  pulse: save context of id_proc
//   ctx_restore   out  pulse: restore context of id_proc
//   Set_pid_0     out  pulse: return control to SO
//   ready_mask    out  [3] bit i-1 set = process i ready
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_SO      | SO/BIOS owns the CPU, waiting for any ready process
// S_SEL     | pick next ready process after last_pid, latch as id_proc
// S_RESTORE | ctx_restore pulse for the newly selected process
// S_RUN     | process running until HALT or (preemptive) slice expiry
// S_SAVE    | Set_ctx pulse for the preempted process
// S_EXIT    | Set_pid_0 pulse, control goes back to the SO
// -----------------------------------------------------------------------------
module escalonador_rr
    import so_pkg::*;
#(
    parameter int QUANTUM = 16
)
(
    input  logic                clk,
    input  logic                reset,
    input  logic                proc_add,
    input  logic [PID_W-1:0]    proc_add_id,
    input  logic                HALT,
    input  logic                quantum_over,
    input  logic                preemp_mode,
    output logic [PID_W-1:0]    id_proc,
    output logic                Sel_BIOS,
    output logic                Set_ctx,
    output logic                ctx_restore,
    output logic                Set_pid_0,
    output logic [NUM_PROC-1:0] ready_mask
);

    if (QUANTUM < 1 || QUANTUM > 255) begin : g_quantum_range
        $error("escalonador_rr: QUANTUM must be within 1..255");
    end

    state_t              state;
    state_t              state_nxt;
    logic [PID_W-1:0]    last_pid;
    logic [PID_W-1:0]    last_nxt;
    logic [PID_W-1:0]    id_nxt;
    logic [NUM_PROC-1:0] mask_nxt;
    logic [PID_W-1:0]    sel_pid;
    logic                sel_valid;
    logic                expiry;

    seletor_rr u_seletor (
        .mask     (ready_mask),
        .last_pid (last_pid),
        .next_pid (sel_pid),
        .valid    (sel_valid)
    );

`ifdef ESCALONADOR_QUANTUM_EN
    localparam logic [7:0] Q_LAST = 8'(QUANTUM - 1);

    logic [7:0] q_count;

    // S_RUN is only ever entered from S_RESTORE, so clearing there gives a
    // fresh slice on every entry to S_RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_count <= '0;
        end else if (state == S_RESTORE) begin
            q_count <= '0;
        end else if (state == S_RUN) begin
            q_count <= q_count + 8'd1;
        end
    end

    assign expiry = (state == S_RUN) && (q_count == Q_LAST);

    wire unused_quantum_over = quantum_over;
`else
    assign expiry = quantum_over;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_SO;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        id_nxt    = id_proc;
        last_nxt  = last_pid;
        mask_nxt  = ready_mask;

        case (state)
            S_SO: begin
                if (|ready_mask) begin
                    state_nxt = S_SEL;
                end
            end
            S_SEL: begin
                if (sel_valid) begin
                    state_nxt = S_RESTORE;
                    id_nxt    = sel_pid;
                    last_nxt  = sel_pid;
                end else begin
                    state_nxt = S_SO;
                end
            end
            S_RESTORE: begin
                state_nxt = S_RUN;
            end
            S_RUN: begin
                // HALT has priority over a slice expiry in the same cycle.
                if (HALT) begin
                    state_nxt                  = S_EXIT;
                    mask_nxt[id_proc - 2'd1]   = 1'b0;
                    id_nxt                     = PID_SO;
                end else if (preemp_mode && expiry) begin
                    state_nxt = S_SAVE;
                end
            end
            S_SAVE: begin
                state_nxt = S_SEL;
            end
            S_EXIT: begin
                state_nxt = S_SO;
            end
            default: begin
                state_nxt = S_SO;
                id_nxt    = PID_SO;
            end
        endcase

        // Applied after the HALT clear so a same-cycle add of that id wins.
        if (proc_add && (proc_add_id != PID_SO)) begin
            mask_nxt[proc_add_id - 2'd1] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            id_proc    <= PID_SO;
            last_pid   <= 2'd3;
            ready_mask <= '0;
        end else begin
            id_proc    <= id_nxt;
            last_pid   <= last_nxt;
            ready_mask <= mask_nxt;
        end
    end

    assign Sel_BIOS    = (state == S_SO) || (state == S_EXIT);
    assign Set_ctx     = (state == S_SAVE);
    assign ctx_restore = (state == S_RESTORE);
    assign Set_pid_0   = (state == S_EXIT);

endmodule
